// File: rtl/rv_bram_bw_if.sv
// rtl/rv_bram_bw_if.sv - byte-write port A / read port B bundle for rv_bram_bw
// Parameters must match the rv_bram_bw instance this bundle is bound to.
interface rv_bram_bw_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic             wena;
    logic [NB-1:0]    wbe;
    logic [AW-1:0]    addra;
    logic [WIDTH-1:0] dina;
    logic             renb;
    logic [AW-1:0]    addrb;
    logic [WIDTH-1:0] doutb;
    logic             rvalidb;

    modport master (
        output wena, wbe, addra, dina, renb, addrb,
        input  doutb, rvalidb
    );

    modport slave (
        input  wena, wbe, addra, dina, renb, addrb,
        output doutb, rvalidb
    );
endinterface

// File: rtl/rv_bram_bw.sv
// rtl/rv_bram_bw.sv - simple dual-port RAM, byte-enable write on A, 1/2-cycle read on B
// Optional macro RV_BRAM_BYPASS_EN: same-address read/write returns the merged new word.
module rv_bram_bw #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    rv_bram_bw_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

    generate
        if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
            $error("rv_bram_bw: WIDTH must be a multiple of 8 and at least 8");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("rv_bram_bw: DEPTH must be at least 2");
        end
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("rv_bram_bw: RD_LAT must be 1 or 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_in;
    logic             w_rd_in;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_arr_word;
    logic [WIDTH-1:0] w_rd_word;
    logic [WIDTH-1:0] r_doutb;
    logic             r_rvalidb;

    // Address range checks only bite when DEPTH is not a power of two.
    assign w_wr_in = ({1'b0, bus.addra} < LP_DEPTH);
    assign w_rd_in = ({1'b0, bus.addrb} < LP_DEPTH);
    assign w_wr_en = bus.wena & ~rst & w_wr_in;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wbe[i]) begin
                    r_mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_arr_word = '0;
        if (w_rd_in) begin
            w_arr_word = r_mem[bus.addrb];
        end
    end

`ifdef RV_BRAM_BYPASS_EN
    // Write-first on collision: enabled bytes come straight from dina.
    always_comb begin
        w_rd_word = w_arr_word;
        if (w_wr_en && (bus.addra == bus.addrb)) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wbe[i]) begin
                    w_rd_word[8*i +: 8] = bus.dina[8*i +: 8];
                end
            end
        end
    end
`else
    assign w_rd_word = w_arr_word;
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] r_pipe_data;
            logic             r_pipe_valid;

            // Word is captured at the issuing edge, so a later write cannot disturb it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pipe_valid <= 1'b0;
                    r_pipe_data  <= '0;
                    r_rvalidb    <= 1'b0;
                    r_doutb      <= '0;
                end else begin
                    r_pipe_valid <= bus.renb;
                    if (bus.renb) begin
                        r_pipe_data <= w_rd_word;
                    end
                    r_rvalidb <= r_pipe_valid;
                    if (r_pipe_valid) begin
                        r_doutb <= r_pipe_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rvalidb <= 1'b0;
                    r_doutb   <= '0;
                end else begin
                    r_rvalidb <= bus.renb;
                    if (bus.renb) begin
                        r_doutb <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    assign bus.doutb   = r_doutb;
    assign bus.rvalidb = r_rvalidb;
endmodule

// File: tb/tb_rv_bram_bw.sv
// tb/tb_rv_bram_bw.sv - directed vectors for rv_bram_bw at RD_LAT 1/2 and DEPTH 6
module tb_rv_bram_bw;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef RV_BRAM_BYPASS_EN
    localparam logic [31:0] COL = 32'h0000FFFF;
`else
    localparam logic [31:0] COL = 32'h00000000;
`endif

    rv_bram_bw_if #(.WIDTH(32), .DEPTH(16)) bus1 ();
    rv_bram_bw_if #(.WIDTH(32), .DEPTH(16)) bus2 ();
    rv_bram_bw_if #(.WIDTH(32), .DEPTH(6))  bus3 ();

    rv_bram_bw #(.WIDTH(32), .DEPTH(16), .RD_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
    rv_bram_bw #(.WIDTH(32), .DEPTH(16), .RD_LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(bus2));
    rv_bram_bw #(.WIDTH(32), .DEPTH(6),  .RD_LAT(1)) u_np   (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [3:0]  aa;
        logic [31:0] din;
        logic        re;
        logic [3:0]  ab;
        logic        v1;
        logic [31:0] d1;
        logic        v2;
        logic [31:0] d2;
    } vec_t;

    vec_t vt [22];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] be, input logic [3:0] aa,
                         input logic [31:0] din, input logic re, input logic [3:0] ab);
        bus1.wena = we; bus1.wbe = be; bus1.addra = aa; bus1.dina = din;
        bus1.renb = re; bus1.addrb = ab;
        bus2.wena = we; bus2.wbe = be; bus2.addra = aa; bus2.dina = din;
        bus2.renb = re; bus2.addrb = ab;
    endtask

    task automatic drive3(input logic we, input logic [2:0] aa, input logic [31:0] din,
                          input logic re, input logic [2:0] ab);
        bus3.wena = we; bus3.wbe = 4'hF; bus3.addra = aa; bus3.dina = din;
        bus3.renb = re; bus3.addrb = ab;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [31:0] d,
                           input logic ev, input logic [31:0] ed);
        chk({name, "_v"}, {31'b0, v}, {31'b0, ev});
        chk({name, "_d"}, d, ed);
    endtask

    initial begin
        vt[0]  = '{1'b1, 4'hF, 4'd5, 32'h11223344, 1'b0, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vt[1]  = '{1'b1, 4'h5, 4'd5, 32'hAABBCCDD, 1'b0, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vt[2]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd5, 1'b1, 32'h11BB33DD, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 4'hF, 4'd0, 32'hA0,       1'b0, 4'd0, 1'b0, 32'h11BB33DD, 1'b1, 32'h11BB33DD};
        vt[4]  = '{1'b1, 4'hF, 4'd1, 32'hA1,       1'b0, 4'd0, 1'b0, 32'h11BB33DD, 1'b0, 32'h11BB33DD};
        vt[5]  = '{1'b1, 4'hF, 4'd2, 32'hA2,       1'b0, 4'd0, 1'b0, 32'h11BB33DD, 1'b0, 32'h11BB33DD};
        vt[6]  = '{1'b1, 4'hF, 4'd3, 32'hA3,       1'b0, 4'd0, 1'b0, 32'h11BB33DD, 1'b0, 32'h11BB33DD};
        vt[7]  = '{1'b1, 4'hF, 4'd7, 32'h0,        1'b0, 4'd0, 1'b0, 32'h11BB33DD, 1'b0, 32'h11BB33DD};
        vt[8]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b1, 32'hA0,       1'b0, 32'h11BB33DD};
        vt[9]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd1, 1'b1, 32'hA1,       1'b1, 32'hA0};
        vt[10] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd2, 1'b1, 32'hA2,       1'b1, 32'hA1};
        vt[11] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd3, 1'b1, 32'hA3,       1'b1, 32'hA2};
        vt[12] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'hA3,       1'b1, 32'hA3};
        vt[13] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'hA3,       1'b0, 32'hA3};
        vt[14] = '{1'b1, 4'h3, 4'd7, 32'hFFFFFFFF, 1'b1, 4'd7, 1'b1, COL,          1'b0, 32'hA3};
        vt[15] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd7, 1'b1, 32'h0000FFFF, 1'b1, COL};
        vt[16] = '{1'b1, 4'h0, 4'd5, 32'hDEADBEEF, 1'b1, 4'd5, 1'b1, 32'h11BB33DD, 1'b1, 32'h0000FFFF};
        vt[17] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd5, 1'b1, 32'h11BB33DD, 1'b1, 32'h11BB33DD};
        vt[18] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b1, 32'hA0,       1'b1, 32'h11BB33DD};
        vt[19] = '{1'b1, 4'hF, 4'd0, 32'h12345678, 1'b0, 4'd0, 1'b0, 32'hA0,       1'b1, 32'hA0};
        vt[20] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b1, 32'h12345678, 1'b0, 32'hA0};
        vt[21] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h12345678, 1'b1, 32'h12345678};

        rst = 1'b1;
        drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);
        drive3(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        tick();
        tick();
        chk_out("rst_l1", bus1.rvalidb, bus1.doutb, 1'b0, 32'h0);
        chk_out("rst_l2", bus2.rvalidb, bus2.doutb, 1'b0, 32'h0);
        chk_out("rst_np", bus3.rvalidb, bus3.doutb, 1'b0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].we, vt[i].be, vt[i].aa, vt[i].din, vt[i].re, vt[i].ab);
            tick();
            chk_out($sformatf("row%0d_l1", i), bus1.rvalidb, bus1.doutb, vt[i].v1, vt[i].d1);
            chk_out($sformatf("row%0d_l2", i), bus2.rvalidb, bus2.doutb, vt[i].v2, vt[i].d2);
        end

        // Reset lands while reads are in flight; writes/reads during reset are ignored.
        drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1);
        tick();
        chk_out("mid_issue_l1", bus1.rvalidb, bus1.doutb, 1'b1, 32'hA1);
        rst = 1'b1;
        drive(1'b1, 4'hF, 4'd1, 32'h00000BAD, 1'b1, 4'd2);
        tick();
        chk_out("mid_rst_l1", bus1.rvalidb, bus1.doutb, 1'b0, 32'h0);
        chk_out("mid_rst_l2", bus2.rvalidb, bus2.doutb, 1'b0, 32'h0);
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1);
        tick();
        chk_out("post_rst1_l1", bus1.rvalidb, bus1.doutb, 1'b1, 32'hA1);
        chk_out("post_rst1_l2", bus2.rvalidb, bus2.doutb, 1'b0, 32'h0);
        drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);
        tick();
        chk_out("post_rst2_l1", bus1.rvalidb, bus1.doutb, 1'b0, 32'hA1);
        chk_out("post_rst2_l2", bus2.rvalidb, bus2.doutb, 1'b1, 32'hA1);
        tick();
        chk_out("post_rst3_l2", bus2.rvalidb, bus2.doutb, 1'b0, 32'hA1);

        // DEPTH=6: address 6 is out of range on both ports.
        for (int i = 0; i < 6; i++) begin
            drive3(1'b1, 3'(i), 32'h10 + 32'(i), 1'b0, 3'd0);
            tick();
        end
        drive3(1'b1, 3'd6, 32'h5A, 1'b0, 3'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive3(1'b0, 3'd0, 32'h0, 1'b1, 3'(i));
            tick();
            chk_out($sformatf("np_rd%0d", i), bus3.rvalidb, bus3.doutb, 1'b1, 32'h10 + 32'(i));
        end
        drive3(1'b0, 3'd0, 32'h0, 1'b1, 3'd6);
        tick();
        chk_out("np_rd6", bus3.rvalidb, bus3.doutb, 1'b1, 32'h0);
        drive3(1'b0, 3'd0, 32'h0, 1'b1, 3'd5);
        tick();
        chk_out("np_rd5_again", bus3.rvalidb, bus3.doutb, 1'b1, 32'h15);
        drive3(1'b0, 3'd0, 32'h0, 1'b1, 3'd7);
        tick();
        chk_out("np_rd7", bus3.rvalidb, bus3.doutb, 1'b1, 32'h0);
        drive3(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        tick();
        chk_out("np_idle", bus3.rvalidb, bus3.doutb, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
